arm_instr_encoder: RTL and testbench
====================================

# arm_instr_encoder

Instruction encoder for the single-cycle ARM subset (ADD/SUB/AND/ORR, LDR/STR with immediate offset, B). It is the inverse of the main/ALU decoder path. It accepts field-level instruction requests over a valid/ready handshake and packs each into a 32-bit ARM word, computing branch offsets and memory-offset sign/U bits. It streams the words with sequential word addresses to the instruction-memory write port, which is used by the bench/bootloader to fill program memory.

## Interface
- `ADDR_W`, default 6: instruction-memory word-address width. Byte address = `out_addr << 2`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that clears the address, count and error, and enters RUN.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when `in_valid & in_ready`.
- `in_kind` in 2: request kind. 00 DP_IMM, 01 DP_REG, 10 MEM, 11 BR.
- `in_cond` in 4: condition field, copied to bits 31:28.
- `in_cmd` in 4: DP command. 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
- `in_s` in 1: DP S bit.
- `in_l` in 1: MEM load (1) or store (0). Ignored for BR; L is always 0.
- `in_rn`, `in_rd`, `in_rm` in 4 each: register fields.
- `in_imm` in 24: kind-dependent operand, described below.
- `in_last` in 1: final request of the program.
- `out_valid` out 1: encoded word valid.
- `out_ready` in 1: sink accepts the word.
- `out_addr` out ADDR_W: word address of `out_word`.
- `out_word` out 32: encoded instruction.
- `count` out ADDR_W+1: number of words written since `start`.
- `busy`, `done`, `err` out 1 each.
- `err_code` out 2: 00 none, 01 ILLEGAL_CMD, 10 RANGE, 11 FULL.

## Operation
- Common word layout: {cond, op[1:0], funct[5:0], Rn, Rd, src2[11:0]}.
- DP_IMM: op 00, funct = {1, cmd, S}, src2 = `in_imm[11:0]` ({rot4, imm8}) copied verbatim.
- DP_REG: op 00, funct = {0, cmd, S}, src2 = {`in_imm[4:0]` shamt5, `in_imm[6:5]` sh, 0, Rm}.
- A DP request whose cmd is not one of the four listed commands produces ILLEGAL_CMD.
- MEM: op 01, funct = {0, P=1, U, B=0, W=0, L}.
  - `in_imm[12:0]` is a two's-complement byte offset.
  - U = ~sign. imm12 = |offset|.
  - Offset -4096 produces RANGE.
- BR: op 10, bits 25:24 = 10.
  - `in_imm[ADDR_W-1:0]` is the target word address.
  - imm24 = target − (current `out_addr` + 2), computed in ADDR_W+2 bits and sign-extended to 24 bits (PC+8 rule).
- Rd = 15 is legal for DP and LDR and is encoded verbatim.
- FSM states: IDLE, RUN, EMIT, DONE, ERR.
  - Any state, on `start` → RUN. `start` has priority over `in_valid`; `in_ready` = 0 in that cycle.
  - IDLE: `in_ready` = 0.
  - RUN: `in_ready` = 1.
    - Accept with the full flag set → ERR/FULL.
    - Accept with an encode error → ERR with the corresponding code; no word is emitted.
    - Otherwise register the word and `in_last` → EMIT.
  - EMIT: `out_valid` = 1 and `in_ready` = 0.
    - On `out_ready`: address+1 (full flag set if the address was 2^ADDR_W−1, no wrap) and count+1.
    - Then → DONE if the held last is set, else → RUN.
  - DONE: `done` = 1. Sticky until `start`.
  - ERR: `err` = 1 and `err_code` held. Sticky until `start`; requests are refused.
- `busy` = RUN | EMIT.

## Timing
- Reset: state IDLE. `in_ready`, `out_valid`, `busy`, `done`, `err` = 0. `err_code` = 00, `out_addr` = 0, `out_word` = 0, `count` = 0, full flag cleared.
- Request accepted at edge N → `out_valid` high in cycle N+1.
- Maximum throughput is one word per 2 cycles.
- `out_word` and `out_addr` are registered and stay stable while `out_valid & ~out_ready`.
- `reset` mid-EMIT drops the pending word. No write handshake completes in that cycle.
- `start` during EMIT abandons the word: `out_valid` = 0 the next cycle and the address restarts at 0.

## Structure
- Package `arm_isa_pkg`:
  - kind enum, cmd constants, op codes, err_code enum, COND_AL = 4'hE;
  - funct bit-position localparams, shared with the decoder.
- Sub-module `arm_word_pack`: combinational fields + current address → {word, err_code}.
- The top level holds the FSM, address/count registers, full flag and output registers.

## Test plan
- `start`; DP_IMM, cond E, ADD, S0, Rn0, Rd1, imm 0x005 → `out_word` 0xE2801005, `out_addr` 0, `count` 1.
- DP_REG SUB, S1, Rn2, Rd3, Rm4, shamt 0 → 0xE0523004.
  - LDR Rd1, Rn0, offset −8 → 0xE5101008.
  - STR Rd2, Rn0, offset +4 → 0xE5802004.
- BR request at address 3 with target 1 and `in_last` = 1 → 0xEAFFFFFC. Then `done` = 1 and `in_ready` = 0.
- DP cmd 1111 → ERR, `err_code` 01, `out_valid` never asserted.
  - MEM offset −4096 → `err_code` 10.
  - With ADDR_W = 2: after 4 words, a 5th request → `err_code` 11, `count` 4.
- Hold `out_ready` low for 5 cycles → word and address stable, `in_ready` 0. Then assert `reset` mid-EMIT → all outputs at their reset values next cycle.
- `start` asserted together with `in_valid` → request not accepted. Next cycle the request is accepted at address 0.

Source files
------------

// File: rtl/arm_isa_pkg.sv
// Shared ISA constants for the ARM subset encoder and its decoder counterpart.
package arm_isa_pkg;

  // Request kinds accepted by the encoder.
  typedef enum logic [1:0] {
    KIND_DP_IMM = 2'b00,
    KIND_DP_REG = 2'b01,
    KIND_MEM    = 2'b10,
    KIND_BR     = 2'b11
  } kind_e;

  // Error codes reported by the encoder.
  typedef enum logic [1:0] {
    ERR_NONE        = 2'b00,
    ERR_ILLEGAL_CMD = 2'b01,
    ERR_RANGE       = 2'b10,
    ERR_FULL        = 2'b11
  } err_code_e;

  // Data-processing commands supported by the ALU.
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Major opcodes (instruction bits 27:26).
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Branch bits 25:24 (link bit clear).
  localparam logic [1:0] BR_FUNCT = 2'b10;

  localparam logic [3:0] COND_AL = 4'hE;

  // Bit positions inside the 6-bit funct field (instruction bits 25:20).
  localparam int FUNCT_I      = 5;
  localparam int FUNCT_CMD_HI = 4;
  localparam int FUNCT_CMD_LO = 1;
  localparam int FUNCT_S      = 0;
  localparam int FUNCT_P      = 4;
  localparam int FUNCT_U      = 3;
  localparam int FUNCT_B      = 2;
  localparam int FUNCT_W      = 1;
  localparam int FUNCT_L      = 0;

  // True when cmd is one of the four implemented DP commands.
  function automatic logic is_dp_cmd(input logic [3:0] cmd);
    case (cmd)
      CMD_AND, CMD_SUB, CMD_ADD, CMD_ORR: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm_word_pack.sv
// Combinational packer: request fields plus current word address -> 32-bit word and error code.
module arm_word_pack
  import arm_isa_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  kind_e             kind,
  input  logic [3:0]        cond,
  input  logic [3:0]        cmd,
  input  logic              s,
  input  logic              l,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [3:0]        rm,
  input  logic [23:0]       imm,
  input  logic [ADDR_W-1:0] cur_addr,
  output logic [31:0]       word,
  output err_code_e         err_code
);

  // Memory offset: 13-bit two's complement, encoded as sign (U) plus magnitude.
  logic [12:0] mem_off;
  logic        mem_neg;
  logic [12:0] mem_mag;

  // Branch offset: target minus (PC+8) in words, with two guard bits for the sign.
  logic [ADDR_W+1:0] br_target;
  logic [ADDR_W+1:0] br_pc8;
  logic [ADDR_W+1:0] br_diff;
  logic [23:0]       br_imm24;

  // Bits of the operand that no request kind consumes.
  logic unused_imm_bits;

  assign mem_off   = imm[12:0];
  assign mem_neg   = mem_off[12];
  assign mem_mag   = mem_neg ? (13'd0 - mem_off) : mem_off;
  assign br_target = {2'b00, imm[ADDR_W-1:0]};
  assign br_pc8    = {2'b00, cur_addr} + (ADDR_W+2)'(2);
  assign br_diff   = br_target - br_pc8;
  assign br_imm24  = {{(24-ADDR_W-2){br_diff[ADDR_W+1]}}, br_diff};
  assign unused_imm_bits = ^imm[23:13];

  // Field assembly per request kind; errors are flagged alongside the word.
  always_comb begin
    logic [5:0]  funct;
    logic [11:0] src2;
    funct    = '0;
    src2     = '0;
    word     = '0;
    err_code = ERR_NONE;
    case (kind)
      KIND_DP_IMM, KIND_DP_REG: begin
        funct[FUNCT_I]                   = (kind == KIND_DP_IMM);
        funct[FUNCT_CMD_HI:FUNCT_CMD_LO] = cmd;
        funct[FUNCT_S]                   = s;
        if (kind == KIND_DP_IMM) begin
          src2 = imm[11:0];
        end else begin
          src2 = {imm[4:0], imm[6:5], 1'b0, rm};
        end
        word = {cond, OP_DP, funct, rn, rd, src2};
        if (!is_dp_cmd(cmd)) begin
          err_code = ERR_ILLEGAL_CMD;
        end
      end
      KIND_MEM: begin
        funct[FUNCT_P] = 1'b1;
        funct[FUNCT_U] = ~mem_neg;
        funct[FUNCT_B] = 1'b0;
        funct[FUNCT_W] = 1'b0;
        funct[FUNCT_L] = l;
        src2           = mem_mag[11:0];
        word           = {cond, OP_MEM, funct, rn, rd, src2};
        // Only -4096 has a magnitude that does not fit in 12 bits.
        if (mem_mag[12]) begin
          err_code = ERR_RANGE;
        end
      end
      default: begin
        word = {cond, OP_BR, BR_FUNCT, br_imm24};
      end
    endcase
  end

endmodule

// File: rtl/arm_instr_encoder.sv
// Instruction encoder: accepts field-level requests and streams packed ARM words with sequential addresses.
module arm_instr_encoder
  import arm_isa_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_cmd,
  input  logic              in_s,
  input  logic              in_l,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rm,
  input  logic [23:0]       in_imm,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_word,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_EMIT = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  err_code_e         err_code_q, err_code_d;
  logic [31:0]       word_q, word_d;
  logic              last_q, last_d;

  logic [31:0]       pack_word;
  err_code_e         pack_err;

  arm_word_pack #(
    .ADDR_W (ADDR_W)
  ) u_pack (
    .kind     (kind_e'(in_kind)),
    .cond     (in_cond),
    .cmd      (in_cmd),
    .s        (in_s),
    .l        (in_l),
    .rn       (in_rn),
    .rd       (in_rd),
    .rm       (in_rm),
    .imm      (in_imm),
    .cur_addr (addr_q),
    .word     (pack_word),
    .err_code (pack_err)
  );

  // Next-state and handshake logic; start overrides everything, reset suppresses handshakes.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    full_d     = full_q;
    err_code_d = err_code_q;
    word_d     = word_q;
    last_d     = last_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    if (start) begin
      state_d    = S_RUN;
      addr_d     = '0;
      count_d    = '0;
      full_d     = 1'b0;
      err_code_d = ERR_NONE;
      word_d     = '0;
      last_d     = 1'b0;
    end else if (!reset) begin
      case (state_q)
        S_RUN: begin
          in_ready = 1'b1;
          if (in_valid) begin
            if (full_q) begin
              state_d    = S_ERR;
              err_code_d = ERR_FULL;
            end else if (pack_err != ERR_NONE) begin
              state_d    = S_ERR;
              err_code_d = pack_err;
            end else begin
              state_d = S_EMIT;
              word_d  = pack_word;
              last_d  = in_last;
            end
          end
        end
        S_EMIT: begin
          out_valid = 1'b1;
          if (out_ready) begin
            // The top address is used once; the full flag then blocks further requests.
            if (addr_q == {ADDR_W{1'b1}}) begin
              full_d = 1'b1;
            end else begin
              addr_d = addr_q + 1'b1;
            end
            count_d = count_q + 1'b1;
            state_d = last_q ? S_DONE : S_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      err_code_q <= ERR_NONE;
      word_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      err_code_q <= err_code_d;
      word_q     <= word_d;
      last_q     <= last_d;
    end
  end

  assign out_addr = addr_q;
  assign out_word = word_q;
  assign count    = count_q;
  assign busy     = (state_q == S_RUN) || (state_q == S_EMIT);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);
  assign err_code = err_code_q;

endmodule

// File: tb/tb_arm_instr_encoder.sv
// Directed testbench for arm_instr_encoder (4-word program memory so the full condition is reachable).
module tb_arm_instr_encoder;
  import arm_isa_pkg::*;

  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_kind = '0;
  logic [3:0]        in_cond = '0;
  logic [3:0]        in_cmd = '0;
  logic              in_s = 1'b0;
  logic              in_l = 1'b0;
  logic [3:0]        in_rn = '0;
  logic [3:0]        in_rd = '0;
  logic [3:0]        in_rm = '0;
  logic [23:0]       in_imm = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_word;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  int tests_run = 0;
  int tests_failed = 0;

  arm_instr_encoder #(.ADDR_W(ADDR_W)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_cond   (in_cond),
    .in_cmd    (in_cmd),
    .in_s      (in_s),
    .in_l      (in_l),
    .in_rn     (in_rn),
    .in_rd     (in_rd),
    .in_rm     (in_rm),
    .in_imm    (in_imm),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_word  (out_word),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
  endtask

  // Present one request and hold it until accepted (bounded wait).
  task automatic send(input string tag, input logic [1:0] kind, input logic [3:0] cond,
                      input logic [3:0] cmd, input logic s, input logic l,
                      input logic [3:0] rn, input logic [3:0] rd, input logic [3:0] rm,
                      input logic [23:0] imm, input logic last);
    int waited;
    in_kind  = kind;
    in_cond  = cond;
    in_cmd   = cmd;
    in_s     = s;
    in_l     = l;
    in_rn    = rn;
    in_rd    = rd;
    in_rm    = rm;
    in_imm   = imm;
    in_last  = last;
    in_valid = 1'b1;
    #1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check_eq({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
  endtask

  // Check the pending word, then let the sink take it.
  task automatic expect_emit(input string tag, input logic [31:0] exp_word, input logic [31:0] exp_addr);
    check_eq({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
    check_eq({tag, "_out_word"}, out_word, exp_word);
    check_eq({tag, "_out_addr"}, {30'b0, out_addr}, exp_addr);
    tick();
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_flags", {28'b0, busy, done, err, 1'b0}, 32'd0);
    check_eq("rst_err_code", {30'b0, err_code}, 32'd0);
    check_eq("rst_out_word", out_word, 32'd0);
    check_eq("rst_addr_count", {27'b0, count, out_addr}, 32'd0);

    // Program: DP_IMM, DP_REG, LDR, B (last)
    pulse_start();
    check_eq("run_busy", {31'b0, busy}, 32'd1);
    send("dpimm", KIND_DP_IMM, 4'hE, CMD_ADD, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 24'h000005, 1'b0);
    expect_emit("dpimm", 32'hE2801005, 32'd0);
    check_eq("dpimm_count", {29'b0, count}, 32'd1);
    send("dpreg", KIND_DP_REG, 4'hE, CMD_SUB, 1'b1, 1'b0, 4'd2, 4'd3, 4'd4, 24'h000000, 1'b0);
    expect_emit("dpreg", 32'hE0523004, 32'd1);
    send("ldr", KIND_MEM, 4'hE, 4'h0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd0, 24'h001FF8, 1'b0);
    expect_emit("ldr", 32'hE5101008, 32'd2);
    send("br", KIND_BR, 4'hE, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 24'h000001, 1'b1);
    expect_emit("br", 32'hEAFFFFFC, 32'd3);
    check_eq("br_done", {31'b0, done}, 32'd1);
    check_eq("br_in_ready", {31'b0, in_ready}, 32'd0);
    check_eq("br_count", {29'b0, count}, 32'd4);

    // STR with the sink stalled, then reset mid-EMIT
    pulse_start();
    out_ready = 1'b0;
    send("str", KIND_MEM, 4'hE, 4'h0, 1'b0, 1'b0, 4'd0, 4'd2, 4'd0, 24'h000004, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_out_valid", {31'b0, out_valid}, 32'd1);
      check_eq("stall_out_word", out_word, 32'hE5802004);
      check_eq("stall_out_addr", {30'b0, out_addr}, 32'd0);
      check_eq("stall_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_eq("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("midrst_out_word", out_word, 32'd0);
    check_eq("midrst_addr_count", {27'b0, count, out_addr}, 32'd0);
    check_eq("midrst_flags", {28'b0, busy, done, err, in_ready}, 32'd0);
    out_ready = 1'b1;

    // Illegal DP command
    pulse_start();
    send("illegal", KIND_DP_IMM, 4'hE, 4'hF, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 24'h000001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_eq("illegal_out_valid", {31'b0, out_valid}, 32'd0);
      tick();
    end
    check_eq("illegal_err", {31'b0, err}, 32'd1);
    check_eq("illegal_err_code", {30'b0, err_code}, 32'd1);
    check_eq("illegal_in_ready", {31'b0, in_ready}, 32'd0);
    check_eq("illegal_count", {29'b0, count}, 32'd0);

    // Memory offset out of range
    pulse_start();
    check_eq("range_err_cleared", {29'b0, err, err_code}, 32'd0);
    send("range", KIND_MEM, 4'hE, 4'h0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd0, 24'h001000, 1'b0);
    check_eq("range_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("range_err_code", {30'b0, err_code}, 32'd2);

    // Fill all four addresses, then overflow
    pulse_start();
    send("orr", KIND_DP_REG, 4'hE, CMD_ORR, 1'b0, 1'b0, 4'd1, 4'd2, 4'd5, 24'h000023, 1'b0);
    expect_emit("orr", 32'hE18121A5, 32'd0);
    send("and", KIND_DP_IMM, 4'hE, CMD_AND, 1'b1, 1'b0, 4'd3, 4'd4, 4'd0, 24'h0000FF, 1'b0);
    expect_emit("and", 32'hE21340FF, 32'd1);
    send("ldr_pc", KIND_MEM, 4'hE, 4'h0, 1'b0, 1'b1, 4'd0, 4'd15, 4'd0, 24'h000000, 1'b0);
    expect_emit("ldr_pc", 32'hE590F000, 32'd2);
    send("addeq", KIND_DP_IMM, 4'h0, CMD_ADD, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 24'h000001, 1'b0);
    expect_emit("addeq", 32'h02800001, 32'd3);
    send("overflow", KIND_DP_IMM, 4'hE, CMD_ADD, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 24'h000001, 1'b0);
    check_eq("full_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("full_err", {31'b0, err}, 32'd1);
    check_eq("full_err_code", {30'b0, err_code}, 32'd3);
    check_eq("full_count", {29'b0, count}, 32'd4);

    // start together with in_valid: not accepted that cycle
    in_kind  = KIND_DP_IMM;
    in_cond  = 4'hE;
    in_cmd   = CMD_ADD;
    in_s     = 1'b0;
    in_rn    = 4'd0;
    in_rd    = 4'd1;
    in_imm   = 24'h0000AB;
    in_valid = 1'b1;
    start    = 1'b1;
    #1;
    check_eq("startv_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    start = 1'b0;
    #1;
    check_eq("startv_no_emit", {31'b0, out_valid}, 32'd0);
    check_eq("startv_ready_next", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    #1;
    expect_emit("startv", 32'hE28010AB, 32'd0);
    check_eq("startv_count", {29'b0, count}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
